// File: rtl/bytes2bits_stream.sv
// Streaming byte-to-bit unpacker: one byte in per handshake, OUT_W-bit words out, LSB-first.
// Optional per-message word counter on words_o when BYTES2BITS_WORD_CNT_EN is defined.
module bytes2bits_stream #(
  parameter int OUT_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_last_i,
  output logic             byte_ready_o,
  output logic             bits_valid_o,
  output logic [OUT_W-1:0] bits_o,
  output logic             bits_last_o,
  input  logic             bits_ready_i,
  output logic [15:0]      words_o
);

  // state   | meaning
  // S_RUN   | accepting bytes; only full words are offered
  // S_DRAIN | last byte taken; flushing the buffer, final word may be zero-padded

  localparam int BUF_W = OUT_W + 8;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] EIGHT_C = CNT_W'(8);

  if (OUT_W < 1 || OUT_W > 12) begin : g_bad_out_w
    $error("bytes2bits_stream: OUT_W must be in 1..12");
  end

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   bit_buf_q, bit_buf_d, buf_pop;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_pop;
  logic               push, pop;

  // count + 8 <= BUF_W reduces to count <= OUT_W; registers only, no path from bits_ready_i
  assign byte_ready_o = (state_q == S_RUN) && (cnt_q <= OUT_W_C);
  assign bits_valid_o = (state_q == S_RUN) ? (cnt_q >= OUT_W_C) : (cnt_q != '0);
  assign bits_last_o  = (state_q == S_DRAIN) && (cnt_q <= OUT_W_C);
  assign bits_o       = bit_buf_q[OUT_W-1:0];

  assign push = byte_valid_i && byte_ready_o;
  assign pop  = bits_valid_o && bits_ready_i;

  always_comb begin
    buf_pop   = bit_buf_q;
    cnt_pop   = cnt_q;
    if (pop) begin
      buf_pop = bit_buf_q >> OUT_W;
      cnt_pop = (cnt_q > OUT_W_C) ? (cnt_q - OUT_W_C) : '0;
    end
    bit_buf_d = buf_pop;
    cnt_d     = cnt_pop;
    if (push) begin
      bit_buf_d = buf_pop | (BUF_W'(byte_i) << cnt_pop);
      cnt_d     = cnt_pop + EIGHT_C;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (push && byte_last_i) state_d = S_DRAIN;
      S_DRAIN: if (pop && (cnt_pop == '0)) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_RUN;
      bit_buf_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_buf_q <= bit_buf_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef BYTES2BITS_WORD_CNT_EN
  logic [15:0] words_q;
  logic        msg_start_q;

  // The first push of a message always arrives at count 0, so it never coincides with a pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q     <= '0;
      msg_start_q <= 1'b1;
    end else begin
      if (push && msg_start_q) words_q <= pop ? 16'd1 : 16'd0;
      else if (pop)            words_q <= words_q + 16'd1;
      if (push)                                        msg_start_q <= 1'b0;
      else if (state_q == S_DRAIN && state_d == S_RUN) msg_start_q <= 1'b1;
    end
  end

  assign words_o = words_q;
`else
  assign words_o = '0;
`endif

endmodule

// File: doc/bytes2bits_stream.md
Name: bytes2bits_stream

Overview:
Streaming byte-to-bit unpacker; the inverse direction of the existing bits2bytes packer. Accepts one byte per handshake and emits fixed-width bit words of OUT_W bits, LSB-first. Byte j bit 0 is the earliest bit in the stream, matching the bits2bytes convention bits[j*8 +: 8] = byte j. Sits in front of ByteDecode-style consumers in the conversion/compression datapath, with valid/ready on both sides.

Parameters:
OUT_W, 1, bits per output word; legal range 1..12; any other value is an elaboration error.
BUF_W, OUT_W+8, internal bit-buffer width; localparam, not overridable.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
byte_valid_i  in  1  input byte valid
byte_i  in  8  input byte
byte_last_i  in  1  byte is final byte of message; qualified by byte_valid_i
byte_ready_o  out  1  unpacker accepts a byte this cycle
bits_valid_o  out  1  output word valid
bits_o  out  OUT_W  output word; bit 0 is earliest stream bit
bits_last_o  out  1  final word of message; qualified by bits_valid_o
bits_ready_i  in  1  consumer accepts word
words_o  out  16  per-message emitted-word count (see Optional Feature)

Behaviour:
- One clock (clk_i). Reset is asynchronous and active-low (rst_ni).
- Reset values:
  - buffer = 0, count = 0, state = S_RUN.
  - byte_ready_o = 1, bits_valid_o = 0, bits_o = 0, bits_last_o = 0, words_o = 0.
- Registers:
  - buf[BUF_W-1:0] holds the bit buffer; valid bits occupy buf[count-1:0], with buf[0] oldest.
  - count is 0..BUF_W.
  - state is S_RUN or S_DRAIN.
- Handshakes:
  - A push occurs when byte_valid_i && byte_ready_o.
  - A pop occurs when bits_valid_o && bits_ready_i.
  - Once bits_valid_o is asserted, bits_o and bits_last_o hold stable until popped.
- byte_ready_o = (state == S_RUN) && (count + 8 <= BUF_W).
  - Depends only on registers, so there is no combinational path from bits_ready_i to byte_ready_o.
- Output valid:
  - S_RUN: bits_valid_o = (count >= OUT_W).
  - S_DRAIN: bits_valid_o = (count != 0).
- bits_o = buf[OUT_W-1:0].
  - Positions at or above count read 0, so a partial final word is zero-padded.
  - Buffer bits above count are always held at 0.
- Buffer update:
  - Pop: shift buf right by OUT_W; count -= OUT_W, saturating at 0 for a partial drain word.
  - Push: byte_i is written at buf[count' +: 8], where count' is count after any same-cycle pop; then count = count' + 8.
  - Simultaneous push and pop in one cycle is required and must give count = count + 8 - OUT_W.
- Output latency: first word is valid the cycle after the push that makes count >= OUT_W. Zero-bubble throughput when both sides are always ready; no data is ever dropped.
- State machine:
  - S_RUN -> S_DRAIN on a push with byte_last_i = 1.
  - S_DRAIN -> S_RUN on the pop that makes count reach 0.
  - No bytes are accepted in S_DRAIN.
- bits_last_o = (state == S_DRAIN) && (count <= OUT_W). It marks the word that empties the buffer, whether full or padded.
- If a message length in bits is a multiple of OUT_W, the last word is full and no padded word is emitted.
- A last byte arriving at count = 0 with OUT_W > 8 produces exactly one padded word with bits_last_o = 1.
- Reset asserted mid-message (either state) discards buffered bits immediately and returns all outputs to their reset values; no partial word is emitted afterwards.

Optional Feature:
Macro BYTES2BITS_WORD_CNT_EN.
- Defined:
  - words_o is a 16-bit register that increments on every pop and wraps at 0xFFFF -> 0.
  - It holds its value after the last pop of a message.
  - It clears to 0 on the first push of the next message, then that byte is handled normally.
- Undefined: words_o is tied to 0 and no counter logic is synthesised.

Test Plan:
- OUT_W=1, push 0xA5 with last=1, consumer always ready -> bits_o sequence 1,0,1,0,0,1,0,1; bits_last_o only on the 8th word; then state returns to S_RUN and byte_ready_o = 1.
- OUT_W=12, push 0xEF, 0xCD, 0xAB (last on 0xAB) -> words 0xDEF, 0xABC; bits_last_o on 0xABC; no padded word; words_o = 2 with macro defined.
- OUT_W=12, push 0x34, 0x12 (last) -> 0x234, then padded 0x001 with bits_last_o = 1; count returns to 0.
- OUT_W=3, hold bits_ready_i = 0 for 5 cycles while offering 0xFF -> bits_o = 0x7 stays stable; byte_ready_o deasserts once count + 8 > 11; releasing the consumer yields no lost or duplicated bits (checked against a reference bit queue).
- OUT_W=5, random 32-byte message (seed 32'hb17b_2b17), random valid/ready -> concatenated output equals input bytes LSB-first, zero-padded to 260 bits; 52 words; last flag only on word 52.
- Assert rst_ni mid-S_DRAIN with count = 4 -> bits_valid_o = 0 and byte_ready_o = 1 immediately, words_o = 0; a following push 0x0F with OUT_W=4, last=1 -> single word 0xF, then 0x0 with last.
